mem_copy_engine: RTL and testbench
==================================

// Module: mem_copy_engine
// PURPOSE
//  Bus-master block-transfer engine that drives the single-port 8x256 data memory.
//  Works as the initiator side of the memory port: it drives address, write enable
//  and write data, and it consumes the combinational read data.
//  Copies LEN bytes from SRC to DST, or fills LEN bytes at DST with a constant.
//  Sits beside the core. The top-level mux gives the engine the memory port while busy=1.
// PARAMETERS
//  AW  8  memory address width (depth 2**AW)
//  DW  8  memory data width
//  LW  9  length width; allows LEN = 0..2**AW
// PORTS
//  clk        in   1   system clock, rising edge
//  rst_n      in   1   asynchronous active-low reset
//  start      in   1   request pulse; sampled only in IDLE
//  mode       in   1   0 = copy, 1 = fill; sampled with start
//  src        in   AW  source base address (copy); sampled with start
//  dst        in   AW  destination base address; sampled with start
//  len        in   LW  byte count; sampled with start
//  fill_val   in   DW  fill constant; sampled with start
//  abort      in   1   stop the transfer early; sampled in RD/WR
//  mem_addr   out  AW  memory address
//  mem_we     out  1   memory write enable
//  mem_wdata  out  DW  memory write data
//  mem_rdata  in   DW  memory read data; combinational from mem_addr
//  busy       out  1   1 while state is RD or WR (engine owns the port)
//  done       out  1   1-cycle pulse when a transfer ends
//  count      out  LW  bytes written in the current/last transfer
//  csum       out  DW  mod-2**DW sum of all bytes written in the current/last transfer
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE; all outputs 0; internal regs 0. Takes effect mid-transfer too.
//  Interrupted writes never complete.
//  FSM states: IDLE, RD, WR, DONE.
//   IDLE: start=1 at an edge -> latch inputs, clear count and csum.
//     len=0 -> go to DONE (no memory access). Otherwise mode=0 -> RD, mode=1 -> WR.
//   RD (copy only): mem_addr = src+i, mem_we=0. At the edge, mem_rdata is latched into buf -> WR.
//   WR: mem_addr = dst+i, mem_we=1.
//     mem_wdata = buf (copy) or fill_val (fill). The write lands at this edge.
//     On the edge: i++, count++, csum += mem_wdata.
//     Next state: i+1==len or abort=1 -> DONE. Else copy -> RD, fill -> WR.
//   DONE: done=1, busy=0, mem_we=0 -> IDLE.
//  Outside the active states, mem_addr=0, mem_we=0 and mem_wdata=0.
//  Throughput and latency:
//   Copy is 2 cycles/byte: busy lasts 2*len cycles, and done asserts 2*len+1 cycles after the start edge.
//   Fill is 1 cycle/byte: busy lasts len cycles, and done asserts len+1 cycles after the start edge.
//  Address arithmetic is mod 2**AW. Offsets wrap past 0xFF to 0x00 silently.
//  len=2**AW touches every address once.
//  Overlap: copy is strictly ascending, one byte read then one written.
//   dst in (src, src+len) therefore propagates already-copied bytes. This is defined behaviour, not an error.
//  Abort in RD: no write occurs; count is unchanged; -> DONE next.
//  Abort in WR: the current write still completes; -> DONE next.
//  start is ignored in RD/WR/DONE. The sampled inputs are frozen for the whole transfer.
//  count and csum hold their values after DONE until the next accepted start.
//  start and abort in the same IDLE cycle: start wins; abort is ignored.
// TESTING
//  1. Preload mem[0x10..0x13]=11,22,33,44. Copy src=0x10 dst=0x80 len=4.
//     -> mem[0x80..0x83]=11,22,33,44; busy 8 cycles; done at cycle 9; count=4; csum=0xAA.
//  2. Fill dst=0xFE len=4 fill_val=0x5A.
//     -> writes to 0xFE,0xFF,0x00,0x01 (wrap); busy 4 cycles; count=4; csum=0x68.
//  3. len=0, copy. -> mem_we never asserts; done 1 cycle after start; count=0.
//  4. Copy len=10; assert abort during the 3rd WR cycle.
//     -> exactly 3 bytes written; done on the next cycle; count=3.
//  5. Overlap: mem[0x20]=0x01, mem[0x21]=0x02. Copy src=0x20 dst=0x21 len=2.
//     -> mem[0x21]=0x01, mem[0x22]=0x01.
//  6. Drop rst_n mid-copy (during WR).
//     -> outputs 0 immediately and no further writes. After release, start is accepted.
//     A start pulse during busy is ignored (count is unaffected).

Source files
------------

// File: rtl/mem_copy_engine.sv
// Block-transfer engine that owns the single-port data memory while busy.
// It copies len bytes from src to dst, or fills len bytes at dst with a constant.
module mem_copy_engine #(
    parameter int AW = 8,
    parameter int DW = 8,
    parameter int LW = 9
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          mode,
    input  logic [AW-1:0] src,
    input  logic [AW-1:0] dst,
    input  logic [LW-1:0] len,
    input  logic [DW-1:0] fill_val,
    input  logic          abort,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy,
    output logic          done,
    output logic [LW-1:0] count,
    output logic [DW-1:0] csum
);

    typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

    state_t        state, state_next;
    logic [AW-1:0] src_r, dst_r;
    logic [LW-1:0] len_r, idx;
    logic [DW-1:0] fill_r, buf_r;
    logic          mode_r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Offsets wrap mod 2**AW because only the low AW bits of idx feed the adder.
    always_comb begin
        state_next = state;
        mem_addr   = '0;
        mem_we     = 1'b0;
        mem_wdata  = '0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (len == '0)  state_next = DONE;
                    else if (mode)  state_next = WR;
                    else            state_next = RD;
                end
            end
            RD: begin
                busy       = 1'b1;
                mem_addr   = src_r + idx[AW-1:0];
                state_next = abort ? DONE : WR;
            end
            WR: begin
                busy      = 1'b1;
                mem_addr  = dst_r + idx[AW-1:0];
                mem_we    = 1'b1;
                mem_wdata = mode_r ? fill_r : buf_r;
                if ((idx + LW'(1)) == len_r || abort) state_next = DONE;
                else if (mode_r)                      state_next = WR;
                else                                  state_next = RD;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            src_r  <= '0;
            dst_r  <= '0;
            len_r  <= '0;
            fill_r <= '0;
            mode_r <= 1'b0;
            buf_r  <= '0;
            idx    <= '0;
            count  <= '0;
            csum   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        src_r  <= src;
                        dst_r  <= dst;
                        len_r  <= len;
                        fill_r <= fill_val;
                        mode_r <= mode;
                        idx    <= '0;
                        count  <= '0;
                        csum   <= '0;
                    end
                end
                RD: buf_r <= mem_rdata;
                WR: begin
                    idx   <= idx + LW'(1);
                    count <= count + LW'(1);
                    csum  <= csum + mem_wdata;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_copy_engine.sv
// Directed self-checking bench for mem_copy_engine with a behavioural 256-byte memory.
module tb_mem_copy_engine;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       mode = 1'b0;
    logic [7:0] src = '0;
    logic [7:0] dst = '0;
    logic [8:0] len = '0;
    logic [7:0] fill_val = '0;
    logic       abort = 1'b0;
    logic [7:0] mem_addr;
    logic       mem_we;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata;
    logic       busy;
    logic       done;
    logic [8:0] count;
    logic [7:0] csum;

    logic [7:0] mem [256];
    logic       pre_we = 1'b0;
    logic [7:0] pre_addr = '0;
    logic [7:0] pre_data = '0;
    int         write_cnt = 0;

    int pass_cnt = 0;
    int total_cnt = 0;

    mem_copy_engine dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .src(src), .dst(dst),
        .len(len), .fill_val(fill_val), .abort(abort), .mem_addr(mem_addr),
        .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy),
        .done(done), .count(count), .csum(csum)
    );

    always #5 clk = ~clk;

    // Memory model: engine writes take priority; the bench port is only used for preloading.
    always @(posedge clk) begin
        if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
            write_cnt     <= write_cnt + 1;
        end else if (pre_we) begin
            mem[pre_addr] <= pre_data;
        end
    end

    assign mem_rdata = mem[mem_addr];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input int unsigned obs, input int unsigned exp);
        total_cnt++;
        if (obs == exp) pass_cnt++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    task automatic preload(input logic [7:0] a, input logic [7:0] d);
        pre_we   = 1'b1;
        pre_addr = a;
        pre_data = d;
        tick();
        pre_we   = 1'b0;
    endtask

    // Issues one start, then watches busy/done cycle by cycle. Cycle n=1 is the first
    // cycle after the start edge. abort_at / start_at pulse those inputs in cycle n.
    task automatic applyStimulus(input logic m, input logic [7:0] s, input logic [7:0] d,
                                 input logic [8:0] l, input logic [7:0] f,
                                 input int abort_at, input int start_at,
                                 output int busy_cycles, output int done_at, output int writes);
        int w0;
        w0       = write_cnt;
        start    = 1'b1;
        mode     = m;
        src      = s;
        dst      = d;
        len      = l;
        fill_val = f;
        abort    = (abort_at == 0);
        tick();
        start    = 1'b0;
        abort    = 1'b0;
        mode     = ~m;
        src      = 8'h00;
        dst      = 8'h00;
        len      = 9'd3;
        fill_val = 8'hFF;
        busy_cycles = 0;
        done_at     = 0;
        for (int n = 1; n <= 600 && done_at == 0; n++) begin
            abort = (n == abort_at);
            start = (n == start_at);
            if (busy) busy_cycles++;
            if (done) done_at = n;
            else      tick();
        end
        start = 1'b0;
        abort = 1'b0;
        tick();
        writes = write_cnt - w0;
    endtask

    initial begin
        int bc, da, wr, w0;
        $display("[TB] mem_copy_engine directed test");

        // Reset values
        repeat (2) tick();
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_we", mem_we, 0);
        checkOutput("rst_addr", mem_addr, 0);
        checkOutput("rst_count", count, 0);
        checkOutput("rst_csum", csum, 0);
        rst_n = 1'b1;
        tick();

        // 1: plain copy, with an ignored start pulse mid-transfer
        preload(8'h10, 8'h11);
        preload(8'h11, 8'h22);
        preload(8'h12, 8'h33);
        preload(8'h13, 8'h44);
        preload(8'h84, 8'hC4);
        applyStimulus(1'b0, 8'h10, 8'h80, 9'd4, 8'h00, -1, 3, bc, da, wr);
        checkOutput("copy_busy", bc, 8);
        checkOutput("copy_done_at", da, 9);
        checkOutput("copy_writes", wr, 4);
        checkOutput("copy_count", count, 4);
        checkOutput("copy_csum", csum, 8'hAA);
        checkOutput("copy_m80", mem[8'h80], 8'h11);
        checkOutput("copy_m81", mem[8'h81], 8'h22);
        checkOutput("copy_m82", mem[8'h82], 8'h33);
        checkOutput("copy_m83", mem[8'h83], 8'h44);
        checkOutput("copy_m84", mem[8'h84], 8'hC4);
        checkOutput("copy_idle_after", busy, 0);

        // 2: fill that wraps past 0xFF; abort raised together with start is ignored
        preload(8'h02, 8'h33);
        applyStimulus(1'b1, 8'h00, 8'hFE, 9'd4, 8'h5A, 0, -1, bc, da, wr);
        checkOutput("fill_busy", bc, 4);
        checkOutput("fill_done_at", da, 5);
        checkOutput("fill_writes", wr, 4);
        checkOutput("fill_count", count, 4);
        checkOutput("fill_csum", csum, 8'h68);
        checkOutput("fill_mFE", mem[8'hFE], 8'h5A);
        checkOutput("fill_mFF", mem[8'hFF], 8'h5A);
        checkOutput("fill_m00", mem[8'h00], 8'h5A);
        checkOutput("fill_m01", mem[8'h01], 8'h5A);
        checkOutput("fill_m02", mem[8'h02], 8'h33);

        // 3: zero-length copy
        applyStimulus(1'b0, 8'h10, 8'h40, 9'd0, 8'h00, -1, -1, bc, da, wr);
        checkOutput("len0_busy", bc, 0);
        checkOutput("len0_done_at", da, 1);
        checkOutput("len0_writes", wr, 0);
        checkOutput("len0_count", count, 0);
        checkOutput("len0_csum", csum, 0);

        // 4: abort during the third write of a 10-byte copy
        preload(8'hA3, 8'hCC);
        applyStimulus(1'b0, 8'h10, 8'hA0, 9'd10, 8'h00, 6, -1, bc, da, wr);
        checkOutput("abort_done_at", da, 7);
        checkOutput("abort_busy", bc, 6);
        checkOutput("abort_writes", wr, 3);
        checkOutput("abort_count", count, 3);
        checkOutput("abort_csum", csum, 8'h66);
        checkOutput("abort_mA2", mem[8'hA2], 8'h33);
        checkOutput("abort_mA3", mem[8'hA3], 8'hCC);

        // 4b: abort while reading: nothing written
        applyStimulus(1'b0, 8'h10, 8'hA3, 9'd5, 8'h00, 1, -1, bc, da, wr);
        checkOutput("abort_rd_done_at", da, 2);
        checkOutput("abort_rd_writes", wr, 0);
        checkOutput("abort_rd_count", count, 0);

        // 5: overlapping copy propagates the first byte
        preload(8'h20, 8'h01);
        preload(8'h21, 8'h02);
        preload(8'h22, 8'h77);
        applyStimulus(1'b0, 8'h20, 8'h21, 9'd2, 8'h00, -1, -1, bc, da, wr);
        checkOutput("ovl_m21", mem[8'h21], 8'h01);
        checkOutput("ovl_m22", mem[8'h22], 8'h01);
        checkOutput("ovl_csum", csum, 8'h02);

        // 6: reset during the second write of a copy
        preload(8'h91, 8'hEE);
        w0       = write_cnt;
        start    = 1'b1;
        mode     = 1'b0;
        src      = 8'h10;
        dst      = 8'h90;
        len      = 9'd8;
        tick();
        start    = 1'b0;
        repeat (3) tick();
        checkOutput("mid_we_before_rst", mem_we, 1);
        rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_we", mem_we, 0);
        checkOutput("mid_rst_busy", busy, 0);
        checkOutput("mid_rst_addr", mem_addr, 0);
        checkOutput("mid_rst_wdata", mem_wdata, 0);
        checkOutput("mid_rst_count", count, 0);
        checkOutput("mid_rst_csum", csum, 0);
        repeat (3) tick();
        checkOutput("mid_rst_writes", write_cnt - w0, 1);
        checkOutput("mid_rst_m90", mem[8'h90], 8'h11);
        checkOutput("mid_rst_m91", mem[8'h91], 8'hEE);
        rst_n = 1'b1;
        tick();
        applyStimulus(1'b1, 8'h00, 8'hC0, 9'd3, 8'h07, -1, 2, bc, da, wr);
        checkOutput("post_rst_done_at", da, 4);
        checkOutput("post_rst_count", count, 3);
        checkOutput("post_rst_csum", csum, 8'h15);
        checkOutput("post_rst_mC2", mem[8'hC2], 8'h07);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
